cnss_seq_sub: RTL
=================

Name: cnss_seq_sub

Overview:
- Digit-serial conditional-sum subtractor: computes resultOUT = operA - operB - Bin over N bits, processing K bits per clock.
- Uses the team's conditional-sum cell scheme. Each bit precomputes sum/carry for carry-in 0 and 1; a mux chain selects the result.
- Sits beside the combinational adders as the area-lean, multi-cycle subtract path, fronted and backed by valid/ready handshakes.

Parameters:
- N, 32, operand/result width; must be a multiple of K.
- K, 8, bits processed per clock (slice width); number of steps S = N/K.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- operA  input  N  minuend.
- operB  input  N  subtrahend.
- Bin  input  1  borrow in.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- resultOUT  output  N  difference, registered.
- Bout  output  1  unsigned borrow out (1 = operA < operB + Bin).
- ovf  output  1  signed two's-complement overflow.

Behaviour:
- Reset (async assert, synchronous deassert by clk) forces:
  - state = IDLE; in_ready = 1; out_valid = 0; resultOUT = 0; Bout = 0; ovf = 0; step counter = 0.
- Arithmetic: R = operA + ~operB + cin, with initial cin = ~Bin. Each step carries forward its slice carry. Bout = ~(final carry).
- ovf = (A[N-1] != B[N-1]) && (R[N-1] != A[N-1]), evaluated on the latched operands.
- States:
  - IDLE:
    - in_ready = 1.
    - On in_valid: latch operA, ~operB and ~Bin; step = 0; go to RUN.
  - RUN:
    - in_ready = 0.
    - Each clock processes slice [step*K +: K] with the registered carry, writes those K bits of resultOUT and updates the carry register.
    - step increments each clock.
    - When step == S-1, also compute Bout/ovf and go to DONE.
  - DONE:
    - out_valid = 1; resultOUT, Bout and ovf held stable.
    - On out_ready, go to IDLE; out_valid = 0 next cycle.
- Latency: out_valid rises S clock edges after the accepting edge (4 for the defaults).
- Throughput: one operation per S+2 cycles at full out_ready.
- in_ready is high only in IDLE. in_valid in RUN/DONE is ignored, with no side effect. Operand ports may change freely after acceptance.
- out_ready sampled outside DONE has no effect.
- Backpressure: DONE persists indefinitely with outputs frozen until out_ready.
- Reset mid-RUN or mid-DONE: operation aborted, outputs return to reset values immediately, no result is ever presented.
- S = 1 (K = N) is legal: RUN lasts one cycle.
- Elaboration check: N % K != 0 is a fatal error.
- resultOUT bits of steps not yet processed are don't-care until out_valid.

Optional Feature:
- Macro CNSS_ADD_MODE_EN.
- Defined:
  - Adds input port sub (1 bit), latched on accept.
  - sub = 0 computes operA + operB + Bin, with Bin treated as carry in, and Bout is the plain carry out.
  - ovf uses the add rule (A[N-1] == B[N-1]) && (R[N-1] != A[N-1]).
  - sub = 1 is identical to the default behaviour.
- Undefined: no sub port; always subtract.

Decomposition:
- Package cnss_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} cnss_state_t;
  - function clog2-safe step-counter width helper;
  - localparam defaults.
- Sub-module csub_slice (combinational, parameter K):
  - per-bit conditional sum/carry pairs plus the select chain;
  - inputs a[K], b_inv[K], cin; outputs s[K], cout.
  - Instantiated once and reused every step.

Test Plan:
- operA=0x00000005, operB=0x00000003, Bin=0 -> resultOUT=0x00000002, Bout=0, ovf=0; out_valid exactly 4 edges after accept.
- operA=0x00000000, operB=0x00000001, Bin=0 -> 0xFFFFFFFF, Bout=1, ovf=0 (borrow ripples through all 4 steps).
- operA=0x80000000, operB=0x00000001, Bin=0 -> 0x7FFFFFFF, Bout=0, ovf=1. Also operA=0x7FFFFFFF, operB=0xFFFFFFFF -> 0x80000000, ovf=1.
- operA=0x00000010, operB=0x0000000F, Bin=1 -> 0x00000000, Bout=0. Then back-to-back second op is accepted only after the out handshake, in_ready=0 throughout RUN/DONE.
- Hold out_ready=0 for 6 cycles in DONE -> outputs stable, in_valid pulses ignored. Release -> one transfer, IDLE next cycle.
- Assert rst during step 2 of RUN -> out_valid=0, in_ready=1, resultOUT=0 immediately. Next accepted op completes correctly. Randomized 10k-op compare vs reference model with random out_ready.

Source files
------------

// File: rtl/cnss_seq_sub_pkg.sv
// Shared state type, default sizing and step-counter width helper for cnss_seq_sub.
package cnss_pkg;

    localparam int CNSS_N_DEF = 32;
    localparam int CNSS_K_DEF = 8;

    typedef enum logic [1:0] {IDLE, RUN, DONE} cnss_state_t;

    // Keeps the counter at least one bit wide when there is a single step.
    function automatic int cnss_step_w(input int steps);
        return (steps <= 1) ? 1 : $clog2(steps);
    endfunction

endpackage

// File: rtl/cnss_seq_sub_slice.sv
// One K-bit conditional-sum slice: per-bit sum/carry for cin=0 and cin=1, then a select chain.
// Purely combinational, no handshake.
module csub_slice #(
    parameter int K = 8
) (
    input  logic [K-1:0] a,
    input  logic [K-1:0] b_inv,
    input  logic         cin,
    output logic [K-1:0] s,
    output logic         cout
);

    logic [K-1:0] s0, s1, c0, c1;
    logic         carry;

    assign s0 = a ^ b_inv;
    assign s1 = ~s0;
    assign c0 = a & b_inv;
    assign c1 = a | b_inv;

    always_comb begin
        s     = '0;
        carry = cin;
        for (int i = 0; i < K; i++) begin
            s[i]  = carry ? s1[i] : s0[i];
            carry = carry ? c1[i] : c0[i];
        end
        cout = carry;
    end

endmodule

// File: rtl/cnss_seq_sub.sv
// Digit-serial subtractor (add mode with CNSS_ADD_MODE_EN), K bits per clock through one reused slice.
// Latency: out_valid S=N/K edges after accept; holds DONE with frozen outputs until out_ready.
module cnss_seq_sub
    import cnss_pkg::*;
#(
    parameter int N = CNSS_N_DEF,
    parameter int K = CNSS_K_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] operA,
    input  logic [N-1:0] operB,
    input  logic         Bin,
`ifdef CNSS_ADD_MODE_EN
    input  logic         sub,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] resultOUT,
    output logic         Bout,
    output logic         ovf
);

    localparam int S   = N / K;
    localparam int STW = cnss_step_w(S);
    localparam logic [STW-1:0] LAST = STW'(S - 1);

    if (N % K != 0) begin : g_bad_width
        $fatal(1, "cnss_seq_sub: N must be a multiple of K");
    end

    cnss_state_t    state;
    logic [STW-1:0] step;
    logic [N-1:0]   a_q;
    logic [N-1:0]   b_q;
    logic           carry_q;
    logic           sub_q;
    logic           sub_in;
    logic [K-1:0]   sl_s;
    logic           sl_cout;

`ifdef CNSS_ADD_MODE_EN
    assign sub_in = sub;
`else
    assign sub_in = 1'b1;
`endif

    csub_slice #(.K(K)) u_slice (
        .a     (a_q[int'(step) * K +: K]),
        .b_inv (b_q[int'(step) * K +: K]),
        .cin   (carry_q),
        .s     (sl_s),
        .cout  (sl_cout)
    );

    // b_q holds the operand as it enters the adder, so one overflow rule covers add and subtract.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            resultOUT <= '0;
            Bout      <= 1'b0;
            ovf       <= 1'b0;
            step      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            carry_q   <= 1'b0;
            sub_q     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= operA;
                        b_q      <= sub_in ? ~operB : operB;
                        carry_q  <= sub_in ? ~Bin : Bin;
                        sub_q    <= sub_in;
                        step     <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    resultOUT[int'(step) * K +: K] <= sl_s;
                    carry_q <= sl_cout;
                    if (step == LAST) begin
                        step      <= '0;
                        Bout      <= sl_cout ^ sub_q;
                        ovf       <= (a_q[N-1] == b_q[N-1]) && (sl_s[K-1] != a_q[N-1]);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        step <= step + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
